// File: rtl/instr_fetch.sv
// Instruction fetch stage for the single-cycle RV32I core: owns the PC, fetches one word
// over req/ack, holds it for one execute step and halts permanently on any fault.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        ill_instr,
  output logic        halted,
  output logic [1:0]  fault_cause,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [1:0] FC_ILLEGAL   = 2'b01;
  localparam logic [1:0] FC_IMEM_ERR  = 2'b10;
  localparam logic [1:0] FC_MISALIGN  = 2'b11;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instret;
  logic        r_halted;
  logic [1:0]  r_fault_cause;
  logic        w_load_instr;
  logic        w_retire;
  logic        w_fault;
  logic [1:0]  w_fault_code;
  logic        w_req;
  logic        w_valid;
  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = r_pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load_instr = 1'b0;
    w_retire     = 1'b0;
    w_fault      = 1'b0;
    w_fault_code = 2'b00;
    case (r_state)
      S_FETCH: begin
        if (imem_ack) begin
          if (imem_err) begin
            w_state_next = S_HALT;
            w_fault      = 1'b1;
            w_fault_code = FC_IMEM_ERR;
          end else begin
            w_state_next = S_EXEC;
            w_load_instr = 1'b1;
          end
        end
      end
      S_EXEC: begin
        // Illegal instruction outranks both stall and redirect.
        if (ill_instr) begin
          w_state_next = S_HALT;
          w_fault      = 1'b1;
          w_fault_code = FC_ILLEGAL;
        end else if (stall) begin
          w_state_next = S_EXEC;
        end else if (branch_taken && (branch_target[1:0] != 2'b00)) begin
          w_state_next = S_HALT;
          w_fault      = 1'b1;
          w_fault_code = FC_MISALIGN;
        end else begin
          w_state_next = S_FETCH;
          w_retire     = 1'b1;
        end
      end
      S_HALT: begin
        w_state_next = S_HALT;
      end
      default: begin
        w_state_next = S_HALT;
      end
    endcase
  end

  always_comb begin
    w_req   = 1'b0;
    w_valid = 1'b0;
    case (r_state)
      S_FETCH: w_req   = 1'b1;
      S_EXEC:  w_valid = 1'b1;
      default: begin
        w_req   = 1'b0;
        w_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_instr       <= NOP_WORD;
      r_instret     <= 32'd0;
      r_halted      <= 1'b0;
      r_fault_cause <= 2'b00;
    end else begin
      if (w_load_instr) begin
        r_instr <= imem_rdata;
      end
      if (w_retire) begin
        r_instret <= r_instret + 32'd1;
        r_pc      <= branch_taken ? branch_target : w_pc_plus4;
      end
      if (w_fault) begin
        r_halted      <= 1'b1;
        r_fault_cause <= w_fault_code;
      end
    end
  end

  // The request is gated by reset so an outstanding fetch is abandoned at once.
  assign imem_req    = w_req & rst_n;
  assign imem_addr   = r_pc;
  assign instruction = r_instr;
  assign instr_valid = w_valid;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign halted      = r_halted;
  assign fault_cause = r_fault_cause;
  assign instret     = r_instret;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: outputs are sampled 1 time unit after
// each rising edge, inputs are driven at the same point for the following edge.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ill_instr;
  logic        halted;
  logic [1:0]  fault_cause;
  logic [31:0] instret;

  int          n_checks;
  int          n_pass;
  logic [31:0] exp_instr;

  instr_fetch #(.RESET_PC(32'h0000_0000), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_err(imem_err),
    .instruction(instruction), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .ill_instr(ill_instr), .halted(halted), .fault_cause(fault_cause),
    .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ack      = 1'b0;
    imem_rdata    = 32'h0;
    imem_err      = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    ill_instr     = 1'b0;
  endtask

  // Assert reset between edges, check reset values, release before the next edge.
  task automatic do_reset(input string tag);
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_req"},     {31'd0, imem_req},    32'd0);
    check({tag, "_rst_pc"},      pc,                   32'h0);
    check({tag, "_rst_instr"},   instruction,          NOP);
    check({tag, "_rst_valid"},   {31'd0, instr_valid}, 32'd0);
    check({tag, "_rst_halted"},  {31'd0, halted},      32'd0);
    check({tag, "_rst_fault"},   {30'd0, fault_cause}, 32'd0);
    check({tag, "_rst_instret"}, instret,              32'd0);
    step();
    rst_n = 1'b1;
    exp_instr = NOP;
    #1;
    check({tag, "_post_req"},  {31'd0, imem_req}, 32'd1);
    check({tag, "_post_addr"}, imem_addr,         32'h0);
  endtask

  // Fetch at address a with the given wait states; leaves the DUT in EXEC.
  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] w, input int waits);
    for (int i = 0; i < waits; i++) begin
      check({tag, "_wait_req"},   {31'd0, imem_req},    32'd1);
      check({tag, "_wait_addr"},  imem_addr,            a);
      check({tag, "_wait_valid"}, {31'd0, instr_valid}, 32'd0);
      check({tag, "_wait_instr"}, instruction,          exp_instr);
      step();
    end
    check({tag, "_req"},   {31'd0, imem_req},    32'd1);
    check({tag, "_addr"},  imem_addr,            a);
    check({tag, "_fvalid"}, {31'd0, instr_valid}, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = w;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    exp_instr  = w;
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    check({tag, "_instr"}, instruction,          w);
    check({tag, "_pc"},    pc,                   a);
    check({tag, "_pc4"},   pc_plus4,             a + 32'd4);
    check({tag, "_xreq"},  {31'd0, imem_req},    32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clear_inputs();
    rst_n = 1'b1;
    #2;
    do_reset("r0");

    // Zero-wait-state stream: 0,4,8 retire in 6 cycles.
    fetch("f0", 32'h0, 32'h0010_0093, 0);
    step();
    fetch("f4", 32'h4, 32'h0020_0113, 0);
    step();
    fetch("f8", 32'h8, 32'h0030_0193, 0);
    step();
    check("seq_instret", instret, 32'd3);
    check("seq_pc",      pc,      32'hC);

    // Three wait states, then a 5-cycle stall.
    fetch("fC", 32'hC, 32'h0040_0213, 3);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid",   {31'd0, instr_valid}, 32'd1);
      check("stall_pc",      pc,                   32'hC);
      check("stall_instret", instret,              32'd3);
      check("stall_instr",   instruction,          32'h0040_0213);
    end
    stall = 1'b0;
    step();
    check("unstall_instret", instret,   32'd4);
    check("unstall_addr",    imem_addr, 32'h10);

    // Aligned branch from 0x10 to 0x40, back to 0x10, then misaligned target.
    fetch("f10", 32'h10, 32'h0400_0063, 0);
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    step();
    branch_taken  = 1'b0;
    check("br_addr",    imem_addr, 32'h40);
    check("br_instret", instret,   32'd5);
    fetch("f40", 32'h40, 32'hFC00_0863, 0);
    branch_taken  = 1'b1;
    branch_target = 32'h10;
    step();
    branch_taken  = 1'b0;
    check("br2_addr", imem_addr, 32'h10);
    fetch("f10b", 32'h10, 32'h0400_0063, 0);
    branch_taken  = 1'b1;
    branch_target = 32'h42;
    step();
    branch_taken  = 1'b0;
    check("mis_halted",  {31'd0, halted},      32'd1);
    check("mis_fault",   {30'd0, fault_cause}, 32'd3);
    check("mis_pc",      pc,                   32'h10);
    check("mis_instret", instret,              32'd6);
    check("mis_req",     {31'd0, imem_req},    32'd0);
    check("mis_valid",   {31'd0, instr_valid}, 32'd0);

    // Illegal instruction wins over stall and branch; halt ignores everything after.
    do_reset("r1");
    fetch("i0", 32'h0, 32'hFFFF_FFFF, 0);
    ill_instr     = 1'b1;
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    step();
    check("ill_halted", {31'd0, halted},      32'd1);
    check("ill_fault",  {30'd0, fault_cause}, 32'd1);
    check("ill_instret", instret,             32'd0);
    clear_inputs();
    imem_ack      = 1'b1;
    imem_rdata    = 32'h1234_5678;
    branch_taken  = 1'b1;
    branch_target = 32'h80;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hlt_req",   {31'd0, imem_req},    32'd0);
      check("hlt_pc",    pc,                   32'h0);
      check("hlt_instr", instruction,          32'hFFFF_FFFF);
      check("hlt_fault", {30'd0, fault_cause}, 32'd1);
      check("hlt_valid", {31'd0, instr_valid}, 32'd0);
    end

    // Bus error on the fetch at 0x8 keeps the previous instruction.
    do_reset("r2");
    fetch("e0", 32'h0, 32'h0010_0093, 0);
    step();
    fetch("e4", 32'h4, 32'h0020_0113, 0);
    step();
    check("err_addr", imem_addr, 32'h8);
    imem_ack   = 1'b1;
    imem_err   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    clear_inputs();
    check("err_halted",  {31'd0, halted},      32'd1);
    check("err_fault",   {30'd0, fault_cause}, 32'd2);
    check("err_instr",   instruction,          32'h0020_0113);
    check("err_pc",      pc,                   32'h8);
    check("err_instret", instret,              32'd2);

    // Reset mid-fetch drops the request without waiting for a clock edge.
    do_reset("r3");
    step();
    step();
    check("pend_req", {31'd0, imem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req", {31'd0, imem_req}, 32'd0);
    check("async_pc",  pc,                32'h0);
    step();
    rst_n = 1'b1;
    #1;
    check("rel_req",  {31'd0, imem_req}, 32'd1);
    check("rel_addr", imem_addr,         32'h0);

    // PC wrap from 0xFFFF_FFFC to 0.
    fetch("w0", 32'h0, 32'h0000_006F, 0);
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken  = 1'b0;
    fetch("wFC", 32'hFFFF_FFFC, 32'h0010_0093, 0);
    step();
    check("wrap_addr",    imem_addr,         32'h0);
    check("wrap_req",     {31'd0, imem_req}, 32'd1);
    check("wrap_instret", instret,           32'd2);
    check("wrap_halted",  {31'd0, halted},   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
